// File: rtl/load_buffer.sv
// In-order load queue between dispatcher and ROB: address capture, store disambiguation/forwarding, memory read, extended writeback.
// Optional MMIO_STRICT_EN: IO-space loads skip forwarding and wait until they are the ROB head.
module load_buffer #(
    parameter int LB_DEPTH   = 8,
    parameter int ROB_WIDTH  = 4,
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  rob_rst_in,
    input  logic                  dispatcher_lbuffer_en_in,
    input  logic [ROB_WIDTH-1:0]  dispatcher_lbuffer_h_in,
    input  logic [2:0]            dispatcher_lbuffer_width_in,
    input  logic                  dispatcher_lbuffer_signed_in,
    output logic                  lbuffer_dispatcher_full_out,
    input  logic [ROB_WIDTH-1:0]  addrunit_lbuffer_h_in,
    input  logic [ADDR_WIDTH-1:0] addrunit_lbuffer_address_in,
    output logic [ROB_WIDTH-1:0]  lbuffer_rob_index_out,
    input  logic                  rob_lbuffer_disambiguation_in,
    input  logic                  rob_lbuffer_forwarding_en_in,
    input  logic [DATA_WIDTH-1:0] rob_lbuffer_forwarding_data_in,
    input  logic [ROB_WIDTH-1:0]  rob_lbuffer_head_in,
    output logic                  lbuffer_datactrl_en_out,
    output logic [ADDR_WIDTH-1:0] lbuffer_datactrl_addr_out,
    output logic [2:0]            lbuffer_datactrl_width_out,
    input  logic                  datactrl_lbuffer_en_in,
    input  logic [DATA_WIDTH-1:0] datactrl_lbuffer_data_in,
    output logic [ROB_WIDTH-1:0]  lbuffer_rob_h_out,
    output logic [DATA_WIDTH-1:0] lbuffer_rob_result_out
);

    localparam int PTR_W = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LB_DEPTH);
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(LB_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, CHECK, MEM, WB} state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic [LB_DEPTH-1:0]   valid_q, valid_d, signed_q, signed_d, addr_valid_q, addr_valid_d;
    logic [ROB_WIDTH-1:0]  tag_q   [LB_DEPTH];
    logic [ROB_WIDTH-1:0]  tag_d   [LB_DEPTH];
    logic [2:0]            width_q [LB_DEPTH];
    logic [2:0]            width_d [LB_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q  [LB_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d  [LB_DEPTH];
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  enq, deq, head_is_io;

    function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] d,
                                                     input logic [2:0] w, input logic s);
        case (w)
            3'b001:  extend = {{(DATA_WIDTH-8){s & d[7]}}, d[7:0]};
            3'b010:  extend = {{(DATA_WIDTH-16){s & d[15]}}, d[15:0]};
            default: extend = d;
        endcase
    endfunction

`ifdef MMIO_STRICT_EN
    assign head_is_io = (addr_q[head_q][ADDR_WIDTH-1 -: 2] == 2'b11);
`else
    logic unused_rob_head;
    assign head_is_io      = 1'b0;
    assign unused_rob_head = ^rob_lbuffer_head_in;
`endif

    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        full_d       = full_q;
        valid_d      = valid_q;
        signed_d     = signed_q;
        addr_valid_d = addr_valid_q;
        tag_d        = tag_q;
        width_d      = width_q;
        addr_d       = addr_q;
        data_d       = data_q;
        enq          = 1'b0;
        deq          = 1'b0;
        if (rdy_in) begin
            if (rob_rst_in) begin
                valid_d      = '0;
                addr_valid_d = '0;
                head_d       = '0;
                tail_d       = '0;
                count_d      = '0;
                state_d      = IDLE;
            end else begin
                enq = dispatcher_lbuffer_en_in && (count_q < DEPTH_C);
                if (enq) begin
                    valid_d[tail_q]      = 1'b1;
                    addr_valid_d[tail_q] = 1'b0;
                    tag_d[tail_q]        = dispatcher_lbuffer_h_in;
                    width_d[tail_q]      = dispatcher_lbuffer_width_in;
                    signed_d[tail_q]     = dispatcher_lbuffer_signed_in;
                    tail_d               = tail_q + PTR_W'(1);
                end
                // Matches against the post-enqueue view so a same-cycle dispatch catches its address.
                if (addrunit_lbuffer_h_in != '0) begin
                    for (int i = 0; i < LB_DEPTH; i++) begin
                        if (valid_d[i] && (tag_d[i] == addrunit_lbuffer_h_in)) begin
                            addr_valid_d[i] = 1'b1;
                            addr_d[i]       = addrunit_lbuffer_address_in;
                        end
                    end
                end
                case (state_q)
                    IDLE: if (valid_q[head_q] && addr_valid_q[head_q]) state_d = CHECK;
                    CHECK: begin
                        if (head_is_io) begin
                            if (rob_lbuffer_head_in == tag_q[head_q]) state_d = MEM;
                        end else if (rob_lbuffer_disambiguation_in) begin
                            state_d = MEM;
                        end else if (rob_lbuffer_forwarding_en_in) begin
                            data_d  = rob_lbuffer_forwarding_data_in;
                            state_d = WB;
                        end
                    end
                    MEM: if (datactrl_lbuffer_en_in) begin
                        data_d  = datactrl_lbuffer_data_in;
                        state_d = WB;
                    end
                    WB: begin
                        valid_d[head_q]      = 1'b0;
                        addr_valid_d[head_q] = 1'b0;
                        head_d               = head_q + PTR_W'(1);
                        deq                  = 1'b1;
                        state_d              = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
                count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
            end
            full_d = (count_d >= FULL_C);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            valid_q      <= '0;
            signed_q     <= '0;
            addr_valid_q <= '0;
            tag_q        <= '{default: '0};
            width_q      <= '{default: '0};
            addr_q       <= '{default: '0};
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            full_q       <= full_d;
            valid_q      <= valid_d;
            signed_q     <= signed_d;
            addr_valid_q <= addr_valid_d;
            tag_q        <= tag_d;
            width_q      <= width_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end

    assign lbuffer_dispatcher_full_out = full_q;
    assign lbuffer_rob_index_out       = (state_q == CHECK) ? tag_q[head_q] : '0;
    assign lbuffer_datactrl_en_out     = (state_q == MEM);
    assign lbuffer_datactrl_addr_out   = (state_q == MEM) ? addr_q[head_q] : '0;
    assign lbuffer_datactrl_width_out  = (state_q == MEM) ? width_q[head_q] : '0;
    assign lbuffer_rob_h_out           = (state_q == WB && rdy_in && !rob_rst_in) ? tag_q[head_q] : '0;
    assign lbuffer_rob_result_out      = (state_q == WB) ?
                                         extend(data_q, width_q[head_q], signed_q[head_q]) : '0;

endmodule

// File: tb/tb_load_buffer.sv
// Scoreboard bench for load_buffer: directed loads, forwarding, stalls, full, flush, rdy freeze, IO loads.
module tb_load_buffer;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, rob_rst_in;
    logic        disp_en, disp_signed;
    logic [3:0]  disp_h;
    logic [2:0]  disp_width;
    logic        full_out;
    logic [3:0]  au_h;
    logic [17:0] au_addr;
    logic [3:0]  index_out;
    logic        disamb, fwd_en;
    logic [31:0] fwd_data;
    logic [3:0]  rob_head;
    logic        dc_en_out;
    logic [17:0] dc_addr_out;
    logic [2:0]  dc_width_out;
    logic        dc_done;
    logic [31:0] dc_data;
    logic [3:0]  h_out;
    logic [31:0] result_out;

    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q[$];

    always #5 clk_in = ~clk_in;

    load_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_rst_in(rob_rst_in),
        .dispatcher_lbuffer_en_in(disp_en), .dispatcher_lbuffer_h_in(disp_h),
        .dispatcher_lbuffer_width_in(disp_width), .dispatcher_lbuffer_signed_in(disp_signed),
        .lbuffer_dispatcher_full_out(full_out),
        .addrunit_lbuffer_h_in(au_h), .addrunit_lbuffer_address_in(au_addr),
        .lbuffer_rob_index_out(index_out),
        .rob_lbuffer_disambiguation_in(disamb), .rob_lbuffer_forwarding_en_in(fwd_en),
        .rob_lbuffer_forwarding_data_in(fwd_data), .rob_lbuffer_head_in(rob_head),
        .lbuffer_datactrl_en_out(dc_en_out), .lbuffer_datactrl_addr_out(dc_addr_out),
        .lbuffer_datactrl_width_out(dc_width_out),
        .datactrl_lbuffer_en_in(dc_done), .datactrl_lbuffer_data_in(dc_data),
        .lbuffer_rob_h_out(h_out), .lbuffer_rob_result_out(result_out)
    );

    // Monitor: every result pulse must match the oldest expected entry.
    always @(negedge clk_in) begin
        if (h_out != 4'd0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected tag=%0d result=%h required=no pulse", h_out, result_out);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                if ({h_out, result_out} !== e) begin
                    errors++;
                    $display("FAIL sb_result actual tag=%0d data=%h required tag=%0d data=%h",
                             h_out, result_out, e[35:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic dispatch(input logic [3:0] h, input logic [2:0] w, input logic s);
        disp_en = 1'b1; disp_h = h; disp_width = w; disp_signed = s;
        tick;
        disp_en = 1'b0;
    endtask

    task automatic bcast(input logic [3:0] h, input logic [17:0] a);
        au_h = h; au_addr = a;
        tick;
        au_h = 4'd0;
    endtask

    task automatic serve_mem(input logic [17:0] a, input logic [2:0] w, input logic [31:0] d);
        int n = 0;
        while (!dc_en_out && n < 20) begin
            tick;
            n++;
        end
        chk("mem_req_seen", {31'd0, dc_en_out}, 32'd1);
        chk("mem_addr", {14'd0, dc_addr_out}, {14'd0, a});
        chk("mem_width", {29'd0, dc_width_out}, {29'd0, w});
        dc_done = 1'b1; dc_data = d;
        tick;
        dc_done = 1'b0;
    endtask

    task automatic drain_check(input string name);
        repeat (3) tick;
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rob_rst_in = 1'b0;
        disp_en = 1'b0; disp_h = 4'd0; disp_width = 3'd0; disp_signed = 1'b0;
        au_h = 4'd0; au_addr = '0;
        disamb = 1'b1; fwd_en = 1'b0; fwd_data = '0; rob_head = 4'd0;
        dc_done = 1'b0; dc_data = '0;
        repeat (2) tick;
        chk("rst_full", {31'd0, full_out}, 0);
        chk("rst_index", {28'd0, index_out}, 0);
        chk("rst_dc_en", {31'd0, dc_en_out}, 0);
        chk("rst_h_out", {28'd0, h_out}, 0);
        rst_in = 1'b0;
        tick;

        // LW via memory, done two cycles after request
        dispatch(4'd3, 3'b100, 1'b0);
        chk("no_addr_idle_index", {28'd0, index_out}, 0);
        exp_q.push_back({4'd3, 32'hDEADBEEF});
        bcast(4'd3, 18'h00100);
        tick;
        chk("check_index", {28'd0, index_out}, 3);
        tick;
        chk("mem_en", {31'd0, dc_en_out}, 1);
        chk("mem_addr_lw", {14'd0, dc_addr_out}, 32'h100);
        tick; tick;
        chk("mem_en_held", {31'd0, dc_en_out}, 1);
        dc_done = 1'b1; dc_data = 32'hDEADBEEF;
        tick;
        dc_done = 1'b0;
        chk("wb_h_out", {28'd0, h_out}, 3);
        drain_check("drain_lw");

        // Forwarded LB, LBU (same-cycle dispatch+address), LH
        disamb = 1'b0; fwd_en = 1'b1; fwd_data = 32'h12345680;
        dispatch(4'd5, 3'b001, 1'b1);
        exp_q.push_back({4'd5, 32'hFFFFFF80});
        bcast(4'd5, 18'h00020);
        tick;
        chk("fwd_check_index", {28'd0, index_out}, 5);
        chk("fwd_no_mem", {31'd0, dc_en_out}, 0);
        tick;
        chk("fwd_latency_h", {28'd0, h_out}, 5);
        chk("fwd_lb_result", result_out, 32'hFFFFFF80);
        drain_check("drain_lb");

        exp_q.push_back({4'd6, 32'h00000080});
        disp_en = 1'b1; disp_h = 4'd6; disp_width = 3'b001; disp_signed = 1'b0;
        au_h = 4'd6; au_addr = 18'h00020;
        tick;
        disp_en = 1'b0; au_h = 4'd0;
        tick; tick;
        chk("same_cycle_addr_h", {28'd0, h_out}, 6);
        drain_check("drain_lbu");

        fwd_data = 32'h00008001;
        dispatch(4'd7, 3'b010, 1'b1);
        exp_q.push_back({4'd7, 32'hFFFF8001});
        bcast(4'd7, 18'h00040);
        drain_check("drain_lh");

        // Stall in CHECK for 4 cycles, then memory
        disamb = 1'b0; fwd_en = 1'b0;
        dispatch(4'd4, 3'b100, 1'b0);
        exp_q.push_back({4'd4, 32'h0BADF00D});
        bcast(4'd4, 18'h00044);
        tick;
        for (int i = 0; i < 4; i++) begin
            chk("stall_index", {28'd0, index_out}, 4);
            chk("stall_h_out", {28'd0, h_out}, 0);
            chk("stall_no_mem", {31'd0, dc_en_out}, 0);
            tick;
        end
        disamb = 1'b1;
        tick;
        serve_mem(18'h00044, 3'b100, 32'h0BADF00D);
        drain_check("drain_stall");

        // Fill to 8, 9th dropped, address in reverse order
        for (int t = 8; t <= 15; t++) begin
            dispatch(t[3:0], 3'b100, 1'b0);
            if (t == 13) chk("full_at6", {31'd0, full_out}, 0);
            if (t == 14) chk("full_at7", {31'd0, full_out}, 1);
            exp_q.push_back({t[3:0], 32'hA5000000 | t});
        end
        dispatch(4'd1, 3'b100, 1'b0);
        chk("full_after_drop", {31'd0, full_out}, 1);
        for (int t = 15; t >= 8; t--) bcast(t[3:0], 18'(32'h1000 + t * 16));
        bcast(4'd1, 18'h00777);
        for (int t = 8; t <= 15; t++) serve_mem(18'(32'h1000 + t * 16), 3'b100, 32'hA5000000 | t);
        drain_check("drain_full");
        chk("dropped_no_mem", {31'd0, dc_en_out}, 0);
        chk("full_cleared", {31'd0, full_out}, 0);

        // Flush while in MEM, late done ignored
        dispatch(4'd9, 3'b100, 1'b0);
        dispatch(4'd10, 3'b100, 1'b0);
        bcast(4'd9, 18'h00300);
        tick; tick;
        chk("flush_pre_mem", {31'd0, dc_en_out}, 1);
        rob_rst_in = 1'b1;
        tick;
        rob_rst_in = 1'b0;
        chk("flush_dc_en", {31'd0, dc_en_out}, 0);
        chk("flush_full", {31'd0, full_out}, 0);
        dc_done = 1'b1; dc_data = 32'h55555555;
        tick;
        dc_done = 1'b0;
        tick;
        chk("flush_late_no_h", {28'd0, h_out}, 0);

        // Post-flush load with rdy_in freezes in MEM and WB
        dispatch(4'd11, 3'b010, 1'b0);
        exp_q.push_back({4'd11, 32'h0000BEEF});
        bcast(4'd11, 18'h00500);
        tick; tick;
        rdy_in = 1'b0;
        repeat (3) tick;
        chk("rdy_hold_dc_en", {31'd0, dc_en_out}, 1);
        rdy_in = 1'b1;
        serve_mem(18'h00500, 3'b010, 32'h1234BEEF);
        rdy_in = 1'b0;
        #1;
        chk("rdy_h_forced0", {28'd0, h_out}, 0);
        repeat (2) tick;
        rdy_in = 1'b1;
        drain_check("drain_rdy");

        // IO-space load
        disamb = 1'b0; fwd_en = 1'b1; fwd_data = 32'hCAFE0001; rob_head = 4'd0;
        dispatch(4'd2, 3'b100, 1'b0);
`ifdef MMIO_STRICT_EN
        exp_q.push_back({4'd2, 32'h77770002});
        bcast(4'd2, 18'h30004);
        tick;
        for (int i = 0; i < 3; i++) begin
            chk("io_wait_index", {28'd0, index_out}, 2);
            chk("io_wait_h", {28'd0, h_out}, 0);
            tick;
        end
        rob_head = 4'd2;
        tick;
        serve_mem(18'h30004, 3'b100, 32'h77770002);
`else
        exp_q.push_back({4'd2, 32'hCAFE0001});
        bcast(4'd2, 18'h30004);
        tick; tick;
        chk("io_fwd_h", {28'd0, h_out}, 2);
`endif
        drain_check("drain_io");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
